// File: rtl/mem_boot_loader_if.sv
// mem_boot_loader_if: host stream, BRAM write ports and CPU control of the boot loader
interface mem_boot_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int CNT_WIDTH = 11
);
  logic start;
  logic [CNT_WIDTH-1:0] i_count;
  logic [CNT_WIDTH-1:0] d_count;
  logic s_valid;
  logic s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic [ADDR_WIDTH-1:0] i_w_addr;
  logic [DATA_WIDTH-1:0] i_w_dat;
  logic i_w_enb;
  logic [DATA_WIDTH/8-1:0] i_w_byte_enb;
  logic [ADDR_WIDTH-1:0] d_w_addr;
  logic [DATA_WIDTH-1:0] d_w_dat;
  logic d_w_enb;
  logic [DATA_WIDTH/8-1:0] d_w_byte_enb;
  logic d_init_done;
  logic cpu_stall;
  logic busy;
  logic error;
  modport master (
    output start, i_count, d_count, s_valid, s_data,
    input s_ready, i_w_addr, i_w_dat, i_w_enb, i_w_byte_enb,
    input d_w_addr, d_w_dat, d_w_enb, d_w_byte_enb, d_init_done, cpu_stall, busy, error
  );
  modport slave (
    input start, i_count, d_count, s_valid, s_data,
    output s_ready, i_w_addr, i_w_dat, i_w_enb, i_w_byte_enb,
    output d_w_addr, d_w_dat, d_w_enb, d_w_byte_enb, d_init_done, cpu_stall, busy, error
  );
endinterface

// File: rtl/mem_boot_loader.sv
// mem_boot_loader: streams data then instruction images into BRAM while stalling the CPU.
// Optional trailing checksum word: MEM_BOOT_LOADER_CHECKSUM_EN.
module mem_boot_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int I_DEPTH = 1024,
  parameter int D_DEPTH = 1024,
  parameter int CNT_WIDTH = 11
) (
  input logic clk,
  input logic rst,
  mem_boot_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD_D, LOAD_I, CHECK, FINISH, RUN, ERROR} state_t;
`ifdef MEM_BOOT_LOADER_CHECKSUM_EN
  localparam state_t LAST = CHECK;
  logic [DATA_WIDTH-1:0] sum;
`else
  localparam state_t LAST = FINISH;
`endif
  state_t state, state_nx;
  logic [CNT_WIDTH-1:0] i_cnt, d_cnt, idx, idx_nx;
  logic [ADDR_WIDTH-1:0] waddr;
  logic can_start, bad, fire, last;
  assign bus.s_ready = state inside {LOAD_D, LOAD_I, CHECK};
  assign bus.cpu_stall = state != RUN;
  assign bus.busy = state inside {LOAD_D, LOAD_I, CHECK, FINISH};
  assign bus.error = state == ERROR;
  always_comb begin
    can_start = bus.start & (state inside {IDLE, RUN, ERROR});
    bad = (bus.i_count > CNT_WIDTH'(I_DEPTH)) | (bus.d_count > CNT_WIDTH'(D_DEPTH));
    fire = bus.s_valid & bus.s_ready;
    idx_nx = idx + CNT_WIDTH'(1);
    last = idx_nx == (state == LOAD_D ? d_cnt : i_cnt);
    waddr = ADDR_WIDTH'({idx, 2'b00});
    state_nx = state;
    if (can_start)
      state_nx = bad ? ERROR : bus.d_count != '0 ? LOAD_D : bus.i_count != '0 ? LOAD_I : LAST;
    else if (state == FINISH)
      state_nx = RUN;
    else if (fire & last & state == LOAD_D)
      state_nx = i_cnt != '0 ? LOAD_I : LAST;
    else if (fire & last & state == LOAD_I)
      state_nx = LAST;
`ifdef MEM_BOOT_LOADER_CHECKSUM_EN
    else if (fire & state == CHECK)
      state_nx = bus.s_data == sum ? FINISH : ERROR;
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_cnt <= '0;
      d_cnt <= '0;
      idx <= '0;
      bus.d_init_done <= 1'b0;
      bus.i_w_enb <= 1'b0;
      bus.i_w_byte_enb <= '0;
      bus.i_w_addr <= '0;
      bus.i_w_dat <= '0;
      bus.d_w_enb <= 1'b0;
      bus.d_w_byte_enb <= '0;
      bus.d_w_addr <= '0;
      bus.d_w_dat <= '0;
`ifdef MEM_BOOT_LOADER_CHECKSUM_EN
      sum <= '0;
`endif
    end else begin
      bus.i_w_enb <= 1'b0;
      bus.i_w_byte_enb <= '0;
      bus.d_w_enb <= 1'b0;
      bus.d_w_byte_enb <= '0;
      if (can_start) begin
        i_cnt <= bus.i_count;
        d_cnt <= bus.d_count;
        idx <= '0;
        bus.d_init_done <= ~bad & (bus.d_count == '0);
`ifdef MEM_BOOT_LOADER_CHECKSUM_EN
        sum <= '0;
`endif
      end else if (fire & state != CHECK) begin
        idx <= last ? '0 : idx_nx;
`ifdef MEM_BOOT_LOADER_CHECKSUM_EN
        sum <= sum + bus.s_data;
`endif
        if (state == LOAD_D) begin
          bus.d_w_enb <= 1'b1;
          bus.d_w_byte_enb <= '1;
          bus.d_w_addr <= waddr;
          bus.d_w_dat <= bus.s_data;
          bus.d_init_done <= last;
        end else begin
          bus.i_w_enb <= 1'b1;
          bus.i_w_byte_enb <= '1;
          bus.i_w_addr <= waddr;
          bus.i_w_dat <= bus.s_data;
        end
      end else if (state_nx == ERROR) begin
        bus.d_init_done <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_boot_loader.sv
// tb_mem_boot_loader: directed loads with a write scoreboard checked on the falling edge
module tb_mem_boot_loader;
  typedef struct packed {
    logic isi;
    logic [11:0] addr;
    logic [31:0] dat;
    logic dinit;
  } wr_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  wr_t sb[$];
  logic [31:0] dq[$], iq[$], iq2[$], none[$];
  mem_boot_loader_if bus();
  mem_boot_loader dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) if (!rst && (bus.d_w_enb || bus.i_w_enb)) begin
    if (sb.size() == 0) chk("unexpected_write", {bus.i_w_enb, bus.d_w_enb}, 0);
    else begin
      wr_t e;
      e = sb.pop_front();
      chk("w_i_enb", bus.i_w_enb, e.isi);
      chk("w_d_enb", bus.d_w_enb, !e.isi);
      chk("w_addr", e.isi ? bus.i_w_addr : bus.d_w_addr, e.addr);
      chk("w_dat", e.isi ? bus.i_w_dat : bus.d_w_dat, e.dat);
      chk("w_be", e.isi ? bus.i_w_byte_enb : bus.d_w_byte_enb, 4'hf);
      chk("w_dinit", bus.d_init_done, e.dinit);
    end
  end
  task automatic start_pulse(input int dc, input int ic);
    bus.start = 1'b1;
    bus.d_count = 11'(dc);
    bus.i_count = 11'(ic);
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic send(input logic [31:0] w, input int gap);
    int k;
    bus.s_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data = w;
    k = 0;
    while (!bus.s_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!bus.s_ready) chk("ready_timeout", 0, 1);
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask
  task automatic load(input logic [31:0] dw[$], input logic [31:0] iw[$], input int gap, input logic [31:0] ck_ofs);
    logic [31:0] sum;
    sum = 0;
    start_pulse(dw.size(), iw.size());
    chk("start_dinit", bus.d_init_done, dw.size() == 0);
    chk("start_stall", bus.cpu_stall, 1);
    foreach (dw[k]) begin
      sum += dw[k];
      sb.push_back('{1'b0, 12'(k * 4), dw[k], k == dw.size() - 1});
      send(dw[k], gap);
    end
    foreach (iw[k]) begin
      sum += iw[k];
      sb.push_back('{1'b1, 12'(k * 4), iw[k], 1'b1});
      send(iw[k], gap);
    end
`ifdef MEM_BOOT_LOADER_CHECKSUM_EN
    send(sum + ck_ofs, gap);
    if (ck_ofs != 0) begin
      chk("ck_error", bus.error, 1);
      chk("ck_stall", bus.cpu_stall, 1);
      chk("ck_dinit", bus.d_init_done, 0);
      chk("ck_busy", bus.busy, 0);
      return;
    end
`endif
    chk("fin_stall", bus.cpu_stall, 1);
    chk("fin_busy", bus.busy, 1);
    @(negedge clk);
    chk("run_stall", bus.cpu_stall, 0);
    chk("run_busy", bus.busy, 0);
    chk("run_dinit", bus.d_init_done, 1);
    chk("run_error", bus.error, 0);
    chk("run_ready", bus.s_ready, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.start = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.i_count = '0;
    bus.d_count = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_stall", bus.cpu_stall, 1);
    chk("rst_error", bus.error, 0);
    chk("rst_ready", bus.s_ready, 0);
    chk("rst_i_enb", bus.i_w_enb, 0);
    chk("rst_d_enb", bus.d_w_enb, 0);
    chk("rst_i_be", bus.i_w_byte_enb, 0);
    chk("rst_d_be", bus.d_w_byte_enb, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_dinit", bus.d_init_done, 0);
    chk("rst_d_addr", bus.d_w_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    dq = '{32'h5, 32'h3, 32'h4};
    for (int k = 0; k < 20; k++) iq.push_back(32'hA000_0000 + k * 7);
    iq2 = '{32'h11, 32'h22};
    load(dq, iq, 0, 0);
    load(dq, iq, 3, 0);
    load(none, iq2, 0, 0);
    start_pulse(1025, 2);
    chk("err_error", bus.error, 1);
    chk("err_ready", bus.s_ready, 0);
    chk("err_stall", bus.cpu_stall, 1);
    chk("err_busy", bus.busy, 0);
    chk("err_dinit", bus.d_init_done, 0);
    bus.s_valid = 1'b1;
    repeat (4) @(negedge clk);
    bus.s_valid = 1'b0;
    chk("err_hold", bus.error, 1);
    load(dq, iq2, 0, 0);
`ifdef MEM_BOOT_LOADER_CHECKSUM_EN
    load(none, '{32'h1, 32'h2}, 0, 0);
    load(none, '{32'h1, 32'h2}, 0, 1);
`endif
    start_pulse(0, 20);
    for (int k = 0; k < 5; k++) begin
      sb.push_back('{1'b1, 12'(k * 4), iq[k], 1'b1});
      send(iq[k], 0);
    end
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_stall", bus.cpu_stall, 1);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_ready", bus.s_ready, 0);
    chk("mid_rst_i_enb", bus.i_w_enb, 0);
    chk("mid_rst_i_addr", bus.i_w_addr, 0);
    chk("mid_rst_dinit", bus.d_init_done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load(none, iq, 0, 0);
    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
